mult_share_arb: RTL and testbench

- Shares one combinational WIDTH x WIDTH unsigned multiplier among NREQ requesters.
- Arbitrates with round-robin priority and allows one transaction in flight at a time.
- Drives the multiplier operand inputs from registers and captures the product into a result register.
- Returns the result through a valid/ready response port, tagged with the requester index.

---
 rtl/mult_share_arb_pkg.sv | 13 +
 rtl/mult_share_arb_rr_pick.sv | 30 +++
 rtl/mult_share_arb.sv | 113 +++++++++++
 tb/tb_mult_share_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encoding and default sizes.
package mult_share_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one external multiplier among NREQ requesters, one transaction at a time.
// Optional completed-handshake counter output done_cnt is enabled by defining MULT_SHARE_ARB_CNT_EN.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_m,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_m,
`ifdef MULT_SHARE_ARB_CNT_EN
  output logic [15:0]           done_cnt,
`endif
  output logic [IDW-1:0]        rsp_id
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready is withheld during reset so no requester believes it was accepted by a discarded edge.
  assign accept    = (state == IDLE) && pick_any && !rst;
  assign req_ready = accept ? pick_grant : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_m     <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            id_q   <= pick_idx;
            rr_ptr <= (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_m     <= mul_m;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_CNT_EN
  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (done_cnt != 16'hFFFF)) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed table, hand sequences, and randomized model comparison.
module tb_mult_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_m;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_m;
  logic [IDW-1:0]        rsp_id;
`ifdef MULT_SHARE_ARB_CNT_EN
  logic [15:0]           done_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_m     (mul_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_m     (rsp_m),
`ifdef MULT_SHARE_ARB_CNT_EN
    .done_cnt  (done_cnt),
`endif
    .rsp_id    (rsp_id)
  );

  // The shared multiplier lives outside the arbiter.
  assign mul_m = {4'b0, mul_a} * {4'b0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                               input logic r);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated transaction from a single requester, checked cycle by cycle.
  task automatic run_single(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] m);
    logic [15:0] va, vb;
    va = '0; vb = '0;
    va[id*4 +: 4] = a;
    vb[id*4 +: 4] = b;
    @(negedge clk);
    applyStimulus(4'(1 << id), va, vb, 1'b1);
    #1 checkOutput("single_ready", int'(req_ready), 1 << id);
    @(negedge clk);
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b1);
    #1;
    checkOutput("single_calc_ready", int'(req_ready), 0);
    checkOutput("single_calc_valid", int'(rsp_valid), 0);
    checkOutput("single_mul_a", int'(mul_a), int'(a));
    checkOutput("single_mul_b", int'(mul_b), int'(b));
    @(negedge clk);
    #1;
    checkOutput("single_rsp_valid", int'(rsp_valid), 1);
    checkOutput("single_rsp_m", int'(rsp_m), int'(m));
    checkOutput("single_rsp_id", int'(rsp_id), id);
    @(negedge clk);
    #1 checkOutput("single_idle_valid", int'(rsp_valid), 0);
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] m;
  } vec_t;

  vec_t vecs[5];

  // Randomized-phase reference state
  logic [3:0] pend;
  logic [3:0] pa[NREQ];
  logic [3:0] pb[NREQ];
  int m_busy, m_ptr, win, pos, exp_id;
  logic [7:0] exp_m;
  logic [3:0] exp_a, exp_b;
  logic rdy;

  initial begin
    logic [15:0] va, vb;
    logic [7:0] all_m[4];

    rst = 1'b1;
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b0);

    vecs[0] = '{0, 4'd10, 4'd10, 8'h64};
    vecs[1] = '{2, 4'd15, 4'd15, 8'hE1};
    vecs[2] = '{3, 4'd0,  4'd7,  8'h00};
    vecs[3] = '{1, 4'd11, 4'd13, 8'h8F};
    vecs[4] = '{3, 4'd15, 4'd9,  8'h87};

    do_reset();
    #1;
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_m", int'(rsp_m), 0);
    checkOutput("reset_rsp_id", int'(rsp_id), 0);
    checkOutput("reset_mul_a", int'(mul_a), 0);
    checkOutput("reset_mul_b", int'(mul_b), 0);
    checkOutput("reset_req_ready", int'(req_ready), 0);

    for (int i = 0; i < 5; i++) run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].m);
`ifdef MULT_SHARE_ARB_CNT_EN
    checkOutput("done_cnt_after_table", int'(done_cnt), 5);
`endif

    // All four requesters at once, grants must come out 0,1,2,3 every three cycles.
    do_reset();
    all_m[0] = 8'h00; all_m[1] = 8'hE1; all_m[2] = 8'h8F; all_m[3] = 8'h87;
    va = {4'd15, 4'd11, 4'd15, 4'd15};
    vb = {4'd9,  4'd13, 4'd15, 4'd0};
    @(negedge clk);
    applyStimulus(4'hF, va, vb, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 checkOutput("all4_grant", int'(req_ready), 1 << k);
      @(negedge clk);
      req_valid[k] = 1'b0;
      #1 checkOutput("all4_calc_ready", int'(req_ready), 0);
      @(negedge clk);
      #1;
      checkOutput("all4_rsp_valid", int'(rsp_valid), 1);
      checkOutput("all4_rsp_m", int'(rsp_m), int'(all_m[k]));
      checkOutput("all4_rsp_id", int'(rsp_id), k);
      @(negedge clk);
    end

    // Backpressure: requester 2 result held for 5 stalled cycles while requester 0 waits.
    do_reset();
    va = '0; vb = '0;
    va[11:8] = 4'd5; vb[11:8] = 4'd6;
    @(negedge clk);
    applyStimulus(4'b0100, va, vb, 1'b0);
    #1 checkOutput("bp_grant2", int'(req_ready), 4'b0100);
    @(negedge clk);
    va[3:0] = 4'd3; vb[3:0] = 4'd3;
    applyStimulus(4'b0001, va, vb, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_hold_valid", int'(rsp_valid), 1);
      checkOutput("bp_hold_m", int'(rsp_m), 8'h1E);
      checkOutput("bp_hold_id", int'(rsp_id), 2);
      checkOutput("bp_hold_ready", int'(req_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 checkOutput("bp_release_valid", int'(rsp_valid), 1);
    @(negedge clk);
    #1 checkOutput("bp_next_grant", int'(req_ready), 4'b0001);
    @(negedge clk);
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("bp_next_m", int'(rsp_m), 8'h09);
    checkOutput("bp_next_id", int'(rsp_id), 0);
    @(negedge clk);

    // Round-robin wrap: after granting 2, pointer is 3, so 3 beats 1.
    do_reset();
    run_single(2, 4'd1, 4'd1, 8'h01);
    va = '0; vb = '0;
    va[15:12] = 4'd9; vb[15:12] = 4'd3;
    va[7:4]   = 4'd2; vb[7:4]   = 4'd7;
    @(negedge clk);
    applyStimulus(4'b1010, va, vb, 1'b1);
    #1 checkOutput("wrap_first_grant", int'(req_ready), 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("wrap_first_m", int'(rsp_m), 8'h1B);
    checkOutput("wrap_first_id", int'(rsp_id), 3);
    @(negedge clk);
    #1 checkOutput("wrap_second_grant", int'(req_ready), 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("wrap_second_m", int'(rsp_m), 8'h0E);
    checkOutput("wrap_second_id", int'(rsp_id), 1);
    @(negedge clk);

    // Reset during CALC discards the transaction and returns the pointer to 0.
    va = '0; vb = '0;
    va[11:8] = 4'd4; vb[11:8] = 4'd4;
    @(negedge clk);
    applyStimulus(4'b0100, va, vb, 1'b1);
    #1 checkOutput("rstmid_grant", int'(req_ready), 4'b0100);
    @(negedge clk);
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("rstmid_no_rsp", int'(rsp_valid), 0);
      checkOutput("rstmid_idle_ready", int'(req_ready), 0);
      @(negedge clk);
    end
    checkOutput("rstmid_mul_a", int'(mul_a), 0);
    va = '0; vb = '0;
    va[7:4] = 4'd3; vb[7:4] = 4'd5;
    va[15:12] = 4'd1; vb[15:12] = 4'd1;
    applyStimulus(4'b1010, va, vb, 1'b1);
    #1 checkOutput("rstmid_grant_from0", int'(req_ready), 4'b0010);
    @(negedge clk);
    applyStimulus(4'd0, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    #1 checkOutput("rstmid_after_m", int'(rsp_m), 8'h0F);
    @(negedge clk);

    // Randomized traffic against a transaction-level reference.
    do_reset();
    pend = '0;
    m_busy = 0;
    m_ptr = 0;
    exp_m = '0; exp_id = 0; exp_a = '0; exp_b = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i] = 1'b1;
          pa[i] = 4'($urandom_range(0, 15));
          pb[i] = 4'($urandom_range(0, 15));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        va[i*4 +: 4] = pa[i];
        vb[i*4 +: 4] = pb[i];
      end
      applyStimulus(pend, va, vb, rdy);
      #1;
      win = -1;
      if (m_busy == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          pos = (m_ptr + k) % NREQ;
          if (win < 0 && pend[pos]) win = pos;
        end
      end
      checkOutput("rnd_req_ready", int'(req_ready), (win >= 0) ? (1 << win) : 0);
      checkOutput("rnd_rsp_valid", int'(rsp_valid), (m_busy == 2) ? 1 : 0);
      if (m_busy == 2) begin
        checkOutput("rnd_rsp_m", int'(rsp_m), int'(exp_m));
        checkOutput("rnd_rsp_id", int'(rsp_id), exp_id);
      end
      if (m_busy == 1) begin
        checkOutput("rnd_mul_a", int'(mul_a), int'(exp_a));
        checkOutput("rnd_mul_b", int'(mul_b), int'(exp_b));
      end
      if (win >= 0) begin
        exp_a  = pa[win];
        exp_b  = pb[win];
        exp_m  = 8'(int'(pa[win]) * int'(pb[win]));
        exp_id = win;
        pend[win] = 1'b0;
        m_ptr  = (win + 1) % NREQ;
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 2;
      end else if (m_busy == 2 && rdy) begin
        m_busy = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
